// File: rtl/regfile_pkg.sv
// Shared types and helpers for the scoreboarded register file.
package regfile_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Elaboration-time ceil(log2(n)), used to size register indices.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits; an issue in the same cycle as a writeback wins.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int DEPTH = 32,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_set_en,
   input  logic [AW-1:0]    i_set_idx,
   input  logic             i_clr_en,
   input  logic [AW-1:0]    i_clr_idx,
   output logic [DEPTH-1:0] o_busy
);

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_set;
   logic [DEPTH-1:0] w_clr;

   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (i_set_en) w_set[i_set_idx] = 1'b1;
      if (i_clr_en) w_clr[i_clr_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) r_busy <= '0;
      else     r_busy <= (r_busy & ~w_clr) | w_set;
   end

   assign o_busy = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with a zeroing sweep after reset,
// write-to-read bypass and a pending-producer scoreboard.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 32,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             writenable,
   input  logic [AW-1:0]    writesel,
   input  logic [WIDTH-1:0] Din,
   input  logic             issue,
   input  logic [AW-1:0]    issuesel,
   input  logic [AW-1:0]    readsel1,
   input  logic [AW-1:0]    readsel2,
   output logic [WIDTH-1:0] Dout1,
   output logic [WIDTH-1:0] Dout2,
   output logic             valid1,
   output logic             valid2,
   output logic             ready
);

   state_t            r_state, w_state_nx;
   logic [AW-1:0]     r_cnt, w_cnt_nx;
   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [DEPTH-1:0]  w_busy;
   logic              w_run;
   logic              w_wr;

   logic [1:0][AW-1:0]    w_rsel;
   logic [1:0][WIDTH-1:0] w_dout;
   logic [1:0]            w_valid;
   logic [1:0]            w_hit;

   assign w_run = (r_state == ST_RUN);
   assign w_wr  = w_run && writenable && (writesel != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      if (r_state == ST_INIT) begin
         w_cnt_nx = r_cnt + 1'b1;
         if (r_cnt == AW'(DEPTH - 1)) w_state_nx = ST_RUN;
      end
   end

   // Storage is not reset; the sweep zeroes one entry per cycle instead.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (!w_run)    r_mem[r_cnt]    <= '0;
         else if (w_wr) r_mem[writesel] <= Din;
      end
   end

   regfile_scoreboard #(.DEPTH(DEPTH)) u_sb (
      .clk       (clk),
      .rst       (rst),
      .i_set_en  (w_run && issue && (issuesel != '0)),
      .i_set_idx (issuesel),
      .i_clr_en  (w_run && writenable),
      .i_clr_idx (writesel),
      .o_busy    (w_busy)
   );

   assign w_rsel = {readsel2, readsel1};

   always_comb begin
      w_dout  = '0;
      w_valid = '0;
      w_hit   = '0;
      for (int p = 0; p < 2; p++) begin
         w_hit[p] = w_wr && (writesel == w_rsel[p]);
         if (w_run) begin
            w_valid[p] = (w_rsel[p] == '0) || !w_busy[w_rsel[p]] || w_hit[p];
            if (w_rsel[p] != '0)
               w_dout[p] = w_hit[p] ? Din : r_mem[w_rsel[p]];
         end
      end
   end

   assign Dout1  = w_dout[0];
   assign Dout2  = w_dout[1];
   assign valid1 = w_valid[0];
   assign valid2 = w_valid[1];
   assign ready  = w_run;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vectors, reset/sweep sequences, a small
// 16x8 instance, and randomized traffic against a behavioural model.
module tb_regfile_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 32x32 instance
   logic        a_rst, a_we, a_iss;
   logic [4:0]  a_ws, a_isel, a_r1, a_r2;
   logic [31:0] a_din, a_dout1, a_dout2;
   logic        a_v1, a_v2, a_ready;

   regfile_sb #(.WIDTH(32), .DEPTH(32)) u_a (
      .clk(clk), .rst(a_rst), .writenable(a_we), .writesel(a_ws), .Din(a_din),
      .issue(a_iss), .issuesel(a_isel), .readsel1(a_r1), .readsel2(a_r2),
      .Dout1(a_dout1), .Dout2(a_dout2), .valid1(a_v1), .valid2(a_v2), .ready(a_ready)
   );

   // 16x8 instance
   logic        b_rst, b_we, b_iss;
   logic [2:0]  b_ws, b_isel, b_r1, b_r2;
   logic [15:0] b_din, b_dout1, b_dout2;
   logic        b_v1, b_v2, b_ready;

   regfile_sb #(.WIDTH(16), .DEPTH(8)) u_b (
      .clk(clk), .rst(b_rst), .writenable(b_we), .writesel(b_ws), .Din(b_din),
      .issue(b_iss), .issuesel(b_isel), .readsel1(b_r1), .readsel2(b_r2),
      .Dout1(b_dout1), .Dout2(b_dout2), .valid1(b_v1), .valid2(b_v2), .ready(b_ready)
   );

   int tests = 0;
   int fails = 0;

   // Behavioural model: cycles since reset, register contents, pending set.
   int          m_cyc;
   logic [31:0] m_mem [32];
   bit          m_busy [32];

   typedef struct {
      logic        we;
      logic [4:0]  ws;
      logic [31:0] din;
      logic        iss;
      logic [4:0]  isel;
      logic [4:0]  r1, r2;
      logic [31:0] d1, d2;
      logic        v1, v2;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_dout(input logic [4:0] sel);
      if (m_cyc < 32 || sel == 5'd0) return 32'd0;
      if (a_we && a_ws == sel) return a_din;
      return m_mem[sel];
   endfunction

   function automatic logic exp_valid(input logic [4:0] sel);
      if (m_cyc < 32) return 1'b0;
      return (sel == 5'd0) || !m_busy[sel] || (a_we && a_ws == sel);
   endfunction

   task automatic model_step();
      if (a_rst) begin
         m_cyc = 0;
         foreach (m_busy[i]) m_busy[i] = 1'b0;
      end else if (m_cyc < 32) begin
         m_cyc++;
         if (m_cyc == 32) foreach (m_mem[i]) m_mem[i] = 32'd0;
      end else begin
         if (a_we && a_ws != 5'd0) m_mem[a_ws] = a_din;
         if (a_we) m_busy[a_ws] = 1'b0;
         if (a_iss && a_isel != 5'd0) m_busy[a_isel] = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
   endtask

   task automatic set_a(input logic rst, input logic we, input logic [4:0] ws,
                        input logic [31:0] din, input logic iss, input logic [4:0] isel,
                        input logic [4:0] r1, input logic [4:0] r2);
      a_rst = rst; a_we = we; a_ws = ws; a_din = din;
      a_iss = iss; a_isel = isel; a_r1 = r1; a_r2 = r2;
   endtask

   task automatic check_model(input string tag);
      check({tag, " dout1"}, a_dout1, exp_dout(a_r1));
      check({tag, " dout2"}, a_dout2, exp_dout(a_r2));
      check({tag, " valid1"}, {31'd0, a_v1}, {31'd0, exp_valid(a_r1)});
      check({tag, " valid2"}, {31'd0, a_v2}, {31'd0, exp_valid(a_r2)});
      check({tag, " ready"}, {31'd0, a_ready}, {31'd0, m_cyc >= 32});
   endtask

   task automatic cyc_a(input logic rst, input logic we, input logic [4:0] ws,
                        input logic [31:0] din, input logic iss, input logic [4:0] isel,
                        input logic [4:0] r1, input logic [4:0] r2, input bit chk);
      @(negedge clk);
      set_a(rst, we, ws, din, iss, isel, r1, r2);
      #1;
      if (chk) check_model("model");
      tick();
   endtask

   // Counts cycles with ready low after a reset edge; 100 means it never rose.
   task automatic count_sweep_a(output int n);
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         set_a(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
         #1;
         if (a_ready) break;
         n++;
         tick();
      end
      if (n < 100) tick();
   endtask

   task automatic addv(input logic we, input logic [4:0] ws, input logic [31:0] din,
                       input logic iss, input logic [4:0] isel, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [31:0] d1, input logic [31:0] d2,
                       input logic v1, input logic v2);
      vec_t v;
      v.we = we; v.ws = ws; v.din = din; v.iss = iss; v.isel = isel;
      v.r1 = r1; v.r2 = r2; v.d1 = d1; v.d2 = d2; v.v1 = v1; v.v2 = v2;
      vecs.push_back(v);
   endtask

   initial begin
      int n;
      // Directed vectors applied from a clean post-sweep state.
      addv(1'b1, 5'd1, 32'h8421, 1'b0, 5'd0, 5'd1, 5'd0, 32'h8421, 32'h0,    1'b1, 1'b1);
      addv(1'b1, 5'd0, 32'h1248, 1'b0, 5'd0, 5'd0, 5'd1, 32'h0,    32'h8421, 1'b1, 1'b1);
      addv(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd1, 5'd0, 32'h8421, 32'h0,    1'b1, 1'b1);
      addv(1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 5'd5, 5'd5, 32'h0,    32'h0,    1'b1, 1'b1);
      addv(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd5, 5'd1, 32'h0,    32'h8421, 1'b0, 1'b1);
      addv(1'b1, 5'd5, 32'hABCD, 1'b0, 5'd0, 5'd5, 5'd5, 32'hABCD, 32'hABCD, 1'b1, 1'b1);
      addv(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd5, 5'd0, 32'hABCD, 32'h0,    1'b1, 1'b1);
      addv(1'b1, 5'd7, 32'h55,   1'b1, 5'd7, 5'd7, 5'd7, 32'h55,   32'h55,   1'b1, 1'b1);
      addv(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd7, 5'd7, 32'h55,   32'h55,   1'b0, 1'b0);
      addv(1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 5'd7, 5'd3, 32'h55,   32'h0,    1'b0, 1'b1);
      addv(1'b1, 5'd7, 32'h66,   1'b0, 5'd0, 5'd7, 5'd7, 32'h66,   32'h66,   1'b1, 1'b1);
      addv(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd7, 5'd3, 32'h66,   32'h0,    1'b1, 1'b1);
      addv(1'b1, 5'd3, 32'h33,   1'b0, 5'd0, 5'd2, 5'd3, 32'h0,    32'h33,   1'b1, 1'b1);
      addv(1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 5'd0, 5'd0, 32'h0,    32'h0,    1'b1, 1'b1);
      addv(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd3, 32'h0,    32'h33,   1'b1, 1'b1);

      set_a(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
      b_rst = 1'b1; b_we = 1'b0; b_ws = '0; b_din = '0; b_iss = 1'b0;
      b_isel = '0; b_r1 = '0; b_r2 = '0;
      m_cyc = 0;
      foreach (m_mem[i]) m_mem[i] = 32'd0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;

      // Reset state, with writes and issues attempted under reset.
      tick();
      @(negedge clk);
      set_a(1'b1, 1'b1, 5'd4, 32'hDEAD, 1'b1, 5'd4, 5'd4, 5'd0);
      #1;
      check("reset ready", {31'd0, a_ready}, 32'd0);
      check("reset dout1", a_dout1, 32'd0);
      check("reset valid1", {31'd0, a_v1}, 32'd0);
      tick();

      count_sweep_a(n);
      check("sweep length 32", n, 32);

      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         set_a(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(i), 5'(31 - i));
         #1;
         check($sformatf("post-sweep r%0d dout", i), a_dout1, 32'd0);
         check($sformatf("post-sweep r%0d valid", i), {31'd0, a_v1}, 32'd1);
         tick();
      end

      foreach (vecs[k]) begin
         @(negedge clk);
         set_a(1'b0, vecs[k].we, vecs[k].ws, vecs[k].din, vecs[k].iss, vecs[k].isel,
               vecs[k].r1, vecs[k].r2);
         #1;
         check($sformatf("vec%0d dout1", k), a_dout1, vecs[k].d1);
         check($sformatf("vec%0d dout2", k), a_dout2, vecs[k].d2);
         check($sformatf("vec%0d valid1", k), {31'd0, a_v1}, {31'd0, vecs[k].v1});
         check($sformatf("vec%0d valid2", k), {31'd0, a_v2}, {31'd0, vecs[k].v2});
         tick();
      end

      // Reset partway through a sweep restarts it from the beginning.
      cyc_a(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
      for (int i = 0; i < 10; i++)
         cyc_a(1'b0, 1'b1, 5'(i + 1), 32'hF00 + i, 1'b1, 5'(i + 2), 5'(i + 1), 5'd0, 1'b1);
      cyc_a(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
      count_sweep_a(n);
      check("mid-sweep reset length", n, 32);

      // Reset after writes and issues clears both data and pending bits.
      cyc_a(1'b0, 1'b1, 5'd9,  32'h1234_5678, 1'b1, 5'd12, 5'd0, 5'd0, 1'b1);
      cyc_a(1'b0, 1'b1, 5'd31, 32'hCAFE_F00D, 1'b1, 5'd9,  5'd9, 5'd12, 1'b1);
      cyc_a(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
      count_sweep_a(n);
      check("reset-after-writes sweep", n, 32);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         set_a(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(i), 5'(i));
         #1;
         check($sformatf("cleared r%0d dout", i), a_dout2, 32'd0);
         check($sformatf("cleared r%0d valid", i), {30'd0, a_v1, a_v2}, 32'd3);
         tick();
      end

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] ws, is, r1, r2;
         bit narrow;
         narrow = ($urandom_range(0, 1) == 0);
         ws = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
         is = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
         r1 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
         r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom);
         cyc_a(($urandom_range(0, 299) == 0), 1'($urandom), ws, $urandom,
               ($urandom_range(0, 9) < 4), is, r1, r2, 1'b1);
      end

      // Small configuration: 8-cycle sweep and top-index write.
      @(negedge clk);
      set_a(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
      b_rst = 1'b1;
      tick();
      @(negedge clk);
      b_rst = 1'b0;
      n = 0;
      while (n < 100) begin
         #1;
         if (b_ready) break;
         n++;
         tick();
         @(negedge clk);
      end
      check("small sweep length 8", n, 8);
      b_we = 1'b1; b_ws = 3'd7; b_din = 16'hFFFF; b_r1 = 3'd7; b_r2 = 3'd7;
      #1;
      check("small bypass r7", {16'd0, b_dout1}, 32'h0000_FFFF);
      tick();
      @(negedge clk);
      b_we = 1'b0;
      for (int i = 0; i < 8; i++) begin
         b_r1 = 3'(i);
         b_r2 = 3'(7 - i);
         #1;
         check($sformatf("small r%0d dout", i), {16'd0, b_dout1},
               (i == 7) ? 32'h0000_FFFF : 32'd0);
         check($sformatf("small r%0d valid", i), {31'd0, b_v1}, 32'd1);
         tick();
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter WIDTH, 32, data bits per register.
REQ-002 Parameter DEPTH, 32, number of registers; power of two, at least 4.
REQ-003 Derived constant AW = clog2(DEPTH), index width; not overridable.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 writenable  input  1  writeback strobe.
REQ-007 writesel  input  AW  writeback register index.
REQ-008 Din  input  WIDTH  writeback data.
REQ-009 issue  input  1  producer-issue strobe; marks a register pending.
REQ-010 issuesel  input  AW  register index marked by issue.
REQ-011 readsel1, readsel2  input  AW  read indices.
REQ-012 Dout1, Dout2  output  WIDTH  read data.
REQ-013 valid1, valid2  output  1  read data is current (not pending).
REQ-014 ready  output  1  initialisation sweep done; block accepts writes and issues.

Function
REQ-015 The block SHALL have two states: INIT and RUN.
REQ-016 INIT SHALL write zero to reg[cnt] each cycle and increment cnt; at cnt == DEPTH-1 it SHALL enter RUN next cycle, so INIT lasts exactly DEPTH cycles.
REQ-017 ready SHALL be 1 only in RUN, as a registered value.
REQ-018 In INIT: writenable and issue ignored; Dout1/Dout2 = 0; valid1/valid2 = 0.
REQ-019 In RUN: writenable=1 with writesel != 0 SHALL write Din into reg[writesel] at the clock edge.
REQ-020 Register 0 SHALL read 0 and valid=1 in RUN; writes and issues to index 0 are discarded.
REQ-021 Reads SHALL be combinational: DoutN = reg[readselN], zero latency.
REQ-022 Bypass: in RUN, when writenable=1, writesel == readselN, and writesel != 0, DoutN SHALL equal Din in the same cycle.
REQ-023 Scoreboard busy[DEPTH]: issue=1 in RUN with issuesel != 0 SHALL set busy[issuesel]; writenable=1 in RUN SHALL clear busy[writesel].
REQ-024 Same-index issue and writeback in one cycle: data is written, busy ends set (issue wins).
REQ-025 validN SHALL equal ready AND (readselN == 0 OR busy[readselN] == 0 OR bypass hit on port N).
REQ-026 readsel1 == readsel2 SHALL give identical Dout and valid on both ports.
REQ-027 Writeback to a non-busy register SHALL be legal: data written, busy stays 0.
REQ-028 Issue to an already-busy register SHALL leave it busy (no counting).

Reset
REQ-029 rst=1 at a clock edge SHALL force state INIT, cnt=0, all busy bits 0, ready=0, from any state including mid-sweep.
REQ-030 The sweep SHALL start on the first edge with rst=0.
REQ-031 Register contents SHALL be zero only after the sweep; no outputs expose data before ready=1.

Structure
REQ-032 Shared package regfile_pkg SHALL hold the state encoding (INIT=0, RUN=1) and the clog2 function.
REQ-033 Scoreboard bits and the set/clear priority SHALL sit in sub-module regfile_scoreboard; storage, bypass and sweep stay in regfile_sb.

Verification
REQ-034 Reset, then idle: ready=0 for exactly 32 cycles, then 1; all 32 registers read 0, valid=1.
REQ-035 RUN: write reg1=0x8421, then reg0=0x1248; read (1,0) -> Dout1=0x8421, Dout2=0, valid1=valid2=1.
REQ-036 issue reg5; read 5 -> valid1=0; next cycle writeback reg5=0xABCD with readsel1=5 -> Dout1=0xABCD, valid1=1 in the same cycle (bypass); following cycle valid1=1 from storage.
REQ-037 Same cycle: issue reg7 and writeback reg7=0x55 -> next cycle Dout=0x55, valid=0.
REQ-038 rst=1 at sweep cycle 10 -> ready stays 0 for a fresh 32 cycles; rst after writes -> busy cleared, registers 0 after the sweep.
REQ-039 WIDTH=16, DEPTH=8: sweep lasts 8 cycles; write reg7=0xFFFF reads back 0xFFFF with no aliasing.
